// File: rtl/gpio_v2_pkg.sv
// Shared register map indices and byte-lane helper for the gpio_v2 port.
package gpio_v2_pkg;

    localparam logic [3:0] REG_PDOR = 4'h0;
    localparam logic [3:0] REG_PSOR = 4'h1;
    localparam logic [3:0] REG_PCOR = 4'h2;
    localparam logic [3:0] REG_PTOR = 4'h3;
    localparam logic [3:0] REG_PDIR = 4'h4;
    localparam logic [3:0] REG_PDDR = 4'h5;
    localparam logic [3:0] REG_PRER = 4'h6;
    localparam logic [3:0] REG_PFER = 4'h7;
    localparam logic [3:0] REG_PISF = 4'h8;
    localparam logic [3:0] REG_FCR  = 4'h9;

    // Expands each strobe bit to cover its 8 data bits.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/gpio_v2_pin_filter.sv
// One input pin: 2-flop synchroniser, programmable glitch filter and edge pulses.
module gpio_v2_pin_filter
    import gpio_v2_pkg::*;
#(
    parameter int FILT_W = 4
) (
    input  logic              mem_clk,
    input  logic              rst,
    input  logic              gpio_in,
    input  logic [FILT_W-1:0] fcr,
    output logic              filt,
    output logic              rise,
    output logic              fall
);

    logic              s1;
    logic              s2;
    logic [FILT_W-1:0] cnt;
    logic              update;

    // filt flips on the (fcr+1)-th consecutive mismatching edge; cnt wraps naturally.
    assign update = (s2 != filt) && (cnt == fcr);
    assign rise   = update & s2;
    assign fall   = update & ~s2;

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == fcr) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_v2.sv
// Memory-mapped GPIO port with atomic set/clear/toggle, filtered inputs and W1C edge flags.
module gpio_v2
    import gpio_v2_pkg::*;
#(
    parameter int TOTAL_GPIOS = 8,
    parameter int FILT_W      = 4
) (
    input  logic                   mem_clk,
    input  logic                   rst,
    input  logic                   mem_valid,
    input  logic [3:0]             mem_addr,
    input  logic [31:0]            mem_wdata,
    input  logic [3:0]             mem_wstrb,
    output logic                   mem_ready,
    output logic [31:0]            mem_rdata,
    input  logic [TOTAL_GPIOS-1:0] gpio_ind,
    output logic [TOTAL_GPIOS-1:0] gpio_do,
    output logic [TOTAL_GPIOS-1:0] gpio_obe,
    output logic                   gpio_irq
);

    logic [TOTAL_GPIOS-1:0] pdor, pddr, prer, pfer, pisf;
    logic [FILT_W-1:0]      fcr;
    logic [TOTAL_GPIOS-1:0] pdir, rise_v, fall_v;
    logic [TOTAL_GPIOS-1:0] wm, wd_g, pisf_set, pisf_clr;
    logic [31:0]            bmask, wd, rd;
    logic                   wr_en;
    logic                   unused_bits;

    assign bmask = strb_mask(mem_wstrb);
    assign wd    = mem_wdata & bmask;
    assign wm    = bmask[TOTAL_GPIOS-1:0];
    assign wd_g  = wd[TOTAL_GPIOS-1:0];
    assign wr_en = mem_valid && (mem_wstrb != 4'b0000);

    assign unused_bits = ^{wd, bmask};

    generate
        for (genvar i = 0; i < TOTAL_GPIOS; i++) begin : g_pin
            gpio_v2_pin_filter #(.FILT_W(FILT_W)) u_filter (
                .mem_clk (mem_clk),
                .rst     (rst),
                .gpio_in (gpio_ind[i]),
                .fcr     (fcr),
                .filt    (pdir[i]),
                .rise    (rise_v[i]),
                .fall    (fall_v[i])
            );
        end
    endgenerate

    // Hardware set is OR'd in after the W1C clear, so a same-edge set wins.
    assign pisf_set = (rise_v & prer) | (fall_v & pfer);
    assign pisf_clr = (wr_en && (mem_addr == REG_PISF)) ? wd_g : '0;

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            pdor <= '0;
            pddr <= '0;
            prer <= '0;
            pfer <= '0;
            pisf <= '0;
            fcr  <= '0;
        end else begin
            pisf <= (pisf & ~pisf_clr) | pisf_set;
            if (wr_en) begin
                case (mem_addr)
                    REG_PDOR: pdor <= (pdor & ~wm) | wd_g;
                    REG_PSOR: pdor <= pdor | wd_g;
                    REG_PCOR: pdor <= pdor & ~wd_g;
                    REG_PTOR: pdor <= pdor ^ wd_g;
                    REG_PDDR: pddr <= (pddr & ~wm) | wd_g;
                    REG_PRER: prer <= (prer & ~wm) | wd_g;
                    REG_PFER: pfer <= (pfer & ~wm) | wd_g;
                    REG_FCR:  fcr  <= (fcr & ~bmask[FILT_W-1:0]) | wd[FILT_W-1:0];
                    default:  ;
                endcase
            end
        end
    end

    always_comb begin
        rd = '0;
        case (mem_addr)
            REG_PDOR: rd[TOTAL_GPIOS-1:0] = pdor;
            REG_PDIR: rd[TOTAL_GPIOS-1:0] = pdir;
            REG_PDDR: rd[TOTAL_GPIOS-1:0] = pddr;
            REG_PRER: rd[TOTAL_GPIOS-1:0] = prer;
            REG_PFER: rd[TOTAL_GPIOS-1:0] = pfer;
            REG_PISF: rd[TOTAL_GPIOS-1:0] = pisf;
            REG_FCR:  rd[FILT_W-1:0]      = fcr;
            default:  rd = '0;
        endcase
    end

    assign mem_ready = mem_valid;
    assign mem_rdata = mem_valid ? rd : 32'h0;
    assign gpio_do   = pdor;
    assign gpio_obe  = pddr;
    assign gpio_irq  = |pisf;

endmodule

// File: tb/tb_gpio_v2.sv
// Directed self-checking bench for gpio_v2 with 8 pins and a 4-bit filter counter.
module tb_gpio_v2;

    logic        mem_clk;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [7:0]  gpio_ind;
    logic [7:0]  gpio_do;
    logic [7:0]  gpio_obe;
    logic        gpio_irq;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rv;

    gpio_v2 #(.TOTAL_GPIOS(8), .FILT_W(4)) dut (
        .mem_clk   (mem_clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .gpio_ind  (gpio_ind),
        .gpio_do   (gpio_do),
        .gpio_obe  (gpio_obe),
        .gpio_irq  (gpio_irq)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge mem_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus write; returns 1 ns after the committing edge.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
        mem_wstrb = strb;
        @(posedge mem_clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'h0;
    endtask

    // Combinational read between edges; consumes no clock edge.
    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = 4'b0000;
        #1;
        data = mem_rdata;
        mem_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 4'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        gpio_ind  = 8'h00;
        tick(2);
        checkOutput("reset_do", {24'h0, gpio_do}, 32'h0);
        checkOutput("reset_obe", {24'h0, gpio_obe}, 32'h0);
        checkOutput("reset_irq", {31'h0, gpio_irq}, 32'h0);
        rst = 1'b0;
        tick(1);

        // Output data register and atomic aliases
        applyStimulus(4'h0, 32'h0000_00A5, 4'hF);
        checkOutput("pdor_write", {24'h0, gpio_do}, 32'hA5);
        applyStimulus(4'h1, 32'h0000_0002, 4'hF);
        checkOutput("psor", {24'h0, gpio_do}, 32'hA7);
        applyStimulus(4'h2, 32'h0000_0080, 4'hF);
        checkOutput("pcor", {24'h0, gpio_do}, 32'h27);
        applyStimulus(4'h3, 32'h0000_000F, 4'hF);
        checkOutput("ptor", {24'h0, gpio_do}, 32'h28);
        bus_read(4'h1, rv);
        checkOutput("psor_read", rv, 32'h0);
        bus_read(4'h0, rv);
        checkOutput("pdor_read", rv, 32'h28);
        checkOutput("rdata_idle", mem_rdata, 32'h0);
        mem_valid = 1'b1;
        #1;
        checkOutput("ready_follows_valid", {31'h0, mem_ready}, 32'h1);
        mem_valid = 1'b0;
        #1;

        // Byte lanes
        applyStimulus(4'h5, 32'h1234_00FF, 4'b0001);
        checkOutput("pddr_lane0", {24'h0, gpio_obe}, 32'hFF);
        applyStimulus(4'h5, 32'h0000_0000, 4'b0010);
        checkOutput("pddr_lane1", {24'h0, gpio_obe}, 32'hFF);
        applyStimulus(4'h1, 32'h0000_00FF, 4'b0010);
        checkOutput("psor_lane1", {24'h0, gpio_do}, 32'h28);
        applyStimulus(4'hA, 32'hFFFF_FFFF, 4'hF);
        bus_read(4'hA, rv);
        checkOutput("reserved_read", rv, 32'h0);

        // FCR=0 pass-through: pin change before edge k shows up after edge k+2
        applyStimulus(4'h6, 32'h0000_0001, 4'hF);
        gpio_ind[0] = 1'b1;
        tick(2);
        bus_read(4'h4, rv);
        checkOutput("pdir_lat_k1", rv, 32'h0);
        tick(1);
        bus_read(4'h4, rv);
        checkOutput("pdir_lat_k2", rv, 32'h01);
        bus_read(4'h8, rv);
        checkOutput("pisf_rise0", rv, 32'h01);
        checkOutput("irq_rise0", {31'h0, gpio_irq}, 32'h1);
        applyStimulus(4'h8, 32'h0000_0001, 4'hF);
        checkOutput("irq_cleared", {31'h0, gpio_irq}, 32'h0);

        // FCR=3 glitch filter on pin 2 with falling-edge enable
        applyStimulus(4'h9, 32'h0000_0003, 4'hF);
        applyStimulus(4'h7, 32'h0000_0004, 4'hF);
        gpio_ind[2] = 1'b1;
        tick(10);
        bus_read(4'h4, rv);
        checkOutput("pdir_pin2_settled", rv, 32'h05);
        bus_read(4'h8, rv);
        checkOutput("pisf_no_rise2", rv, 32'h0);
        gpio_ind[2] = 1'b0;
        tick(3);
        gpio_ind[2] = 1'b1;
        tick(10);
        bus_read(4'h4, rv);
        checkOutput("pdir_short_pulse", rv, 32'h05);
        bus_read(4'h8, rv);
        checkOutput("pisf_short_pulse", rv, 32'h0);
        gpio_ind[2] = 1'b0;
        tick(4);
        gpio_ind[2] = 1'b1;
        tick(1);
        bus_read(4'h4, rv);
        checkOutput("pdir_long_pulse_before", rv, 32'h05);
        tick(1);
        bus_read(4'h4, rv);
        checkOutput("pdir_long_pulse_fall", rv, 32'h01);
        bus_read(4'h8, rv);
        checkOutput("pisf_long_pulse", rv, 32'h04);
        tick(3);
        bus_read(4'h4, rv);
        checkOutput("pdir_still_low", rv, 32'h01);
        tick(1);
        bus_read(4'h4, rv);
        checkOutput("pdir_recovered", rv, 32'h05);
        bus_read(4'h8, rv);
        checkOutput("pisf_no_flag_on_rise", rv, 32'h04);
        applyStimulus(4'h7, 32'h0000_0000, 4'hF);
        bus_read(4'h8, rv);
        checkOutput("pisf_kept_after_pfer_clear", rv, 32'h04);
        applyStimulus(4'h8, 32'h0000_0004, 4'hF);

        // Set beats W1C on the same edge
        applyStimulus(4'h9, 32'h0000_0000, 4'hF);
        applyStimulus(4'h6, 32'h0000_0003, 4'hF);
        gpio_ind[1] = 1'b1;
        tick(2);
        applyStimulus(4'h8, 32'h0000_0002, 4'hF);
        bus_read(4'h8, rv);
        checkOutput("pisf_set_wins", rv, 32'h02);
        checkOutput("irq_set_wins", {31'h0, gpio_irq}, 32'h1);
        applyStimulus(4'h8, 32'h0000_0002, 4'hF);
        bus_read(4'h8, rv);
        checkOutput("pisf_w1c", rv, 32'h0);
        checkOutput("irq_w1c", {31'h0, gpio_irq}, 32'h0);

        // Reset mid-count with a flag pending
        applyStimulus(4'h7, 32'h0000_0001, 4'hF);
        gpio_ind[0] = 1'b0;
        tick(3);
        bus_read(4'h8, rv);
        checkOutput("pisf_fall0", rv, 32'h01);
        applyStimulus(4'h9, 32'h0000_0003, 4'hF);
        applyStimulus(4'h0, 32'h0000_00FF, 4'hF);
        gpio_ind[0] = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        checkOutput("rst_do", {24'h0, gpio_do}, 32'h0);
        checkOutput("rst_obe", {24'h0, gpio_obe}, 32'h0);
        checkOutput("rst_irq", {31'h0, gpio_irq}, 32'h0);
        for (int a = 0; a < 16; a++) begin
            bus_read(a[3:0], rv);
            checkOutput($sformatf("rst_reg%0d", a), rv, 32'h0);
        end
        rst = 1'b0;
        tick(2);
        bus_read(4'h4, rv);
        checkOutput("post_rst_pdir_early", rv, 32'h0);
        tick(1);
        bus_read(4'h4, rv);
        checkOutput("post_rst_pdir", rv, 32'h07);
        bus_read(4'h8, rv);
        checkOutput("post_rst_pisf", rv, 32'h0);
        checkOutput("post_rst_irq", {31'h0, gpio_irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
